// File: rtl/sap_u_control_sequencer.sv
// SAP-U microcode sequencer: T-state stepping, opcode decode to bus control word, ALU flags.

package sap_u_control_sequencer_pkg;

    // Control word in active-high form; output polarity is applied at the ports.
    typedef struct packed {
        logic pc_out;
        logic pc_count;
        logic pc_jump;
        logic mar_load;
        logic ram_out;
        logic ram_write;
        logic ir_load;
        logic ir_out;
        logic a_load;
        logic a_out;
        logic b_load;
        logic alu_out;
        logic alu_sub;
        logic out_load;
        logic flag_load;
    } ctrl_word_t;

    // T0..T4 encode their own step number so t_state can reuse them directly.
    typedef enum logic [2:0] {
        S_T0   = 3'd0,
        S_T1   = 3'd1,
        S_T2   = 3'd2,
        S_T3   = 3'd3,
        S_T4   = 3'd4,
        S_HALT = 3'd5,
        S_IDLE = 3'd7
    } state_t;

endpackage

module sap_u_control_sequencer
    import sap_u_control_sequencer_pkg::*;
#(
    parameter bit          EARLY_END = 1'b1,
    parameter int unsigned OPC_W     = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ram_prog_mode,
    input  logic [OPC_W-1:0] ir_opcode,
    input  logic             alu_carry,
    input  logic             alu_zero,
    output logic             pc_bus_enable_n,
    output logic             pc_count,
    output logic             pc_jump,
    output logic             ram_load_mar_reg,
    output logic             ram_output_enable,
    output logic             ram_control_signal,
    output logic             ir_load_n,
    output logic             ir_bus_enable_n,
    output logic             reg_a_load_n,
    output logic             reg_a_bus_enable_n,
    output logic             reg_b_load_n,
    output logic             alu_enable,
    output logic             alu_subtract,
    output logic             out_load,
    output logic             halted,
    output logic [2:0]       t_state
);

    localparam int unsigned TS_W = 3;
    localparam logic [TS_W-1:0] TS_IDLE = TS_W'(7);

    localparam logic [OPC_W-1:0] OP_LDA = OPC_W'(1);
    localparam logic [OPC_W-1:0] OP_ADD = OPC_W'(2);
    localparam logic [OPC_W-1:0] OP_SUB = OPC_W'(3);
    localparam logic [OPC_W-1:0] OP_STA = OPC_W'(4);
    localparam logic [OPC_W-1:0] OP_LDI = OPC_W'(5);
    localparam logic [OPC_W-1:0] OP_JMP = OPC_W'(6);
    localparam logic [OPC_W-1:0] OP_JC  = OPC_W'(7);
    localparam logic [OPC_W-1:0] OP_JZ  = OPC_W'(8);
    localparam logic [OPC_W-1:0] OP_OUT = OPC_W'(14);
    localparam logic [OPC_W-1:0] OP_HLT = OPC_W'(15);

    state_t     state;
    state_t     state_next;
    ctrl_word_t step_word;
    ctrl_word_t word;
    logic       last_step;
    logic       go_halt;
    logic       carry_flag;
    logic       zero_flag;

    // Step number shown on the LEDs; IDLE and HALT both read as 7.
    function automatic logic [TS_W-1:0] tstate_of(input state_t s);
        logic [TS_W-1:0] ts;
        ts = TS_IDLE;
        if (s == S_T0 || s == S_T1 || s == S_T2 || s == S_T3 || s == S_T4) begin
            ts = TS_W'(s);
        end
        return ts;
    endfunction

    // Decode state + opcode into the step's control word and choose the next step.
    always_comb begin
        step_word  = '0;
        last_step  = 1'b0;
        go_halt    = 1'b0;
        state_next = state;

        unique case (state)
            S_T0: begin
                step_word.pc_out   = 1'b1;
                step_word.mar_load = 1'b1;
            end
            S_T1: begin
                step_word.ram_out  = 1'b1;
                step_word.ir_load  = 1'b1;
                step_word.pc_count = 1'b1;
                case (ir_opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA, OP_LDI, OP_JMP,
                    OP_JC, OP_JZ, OP_OUT, OP_HLT: last_step = 1'b0;
                    default:                      last_step = 1'b1;
                endcase
            end
            S_T2: begin
                case (ir_opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        step_word.ir_out   = 1'b1;
                        step_word.mar_load = 1'b1;
                    end
                    OP_LDI: begin
                        step_word.ir_out = 1'b1;
                        step_word.a_load = 1'b1;
                        last_step        = 1'b1;
                    end
                    OP_JMP: begin
                        step_word.ir_out  = 1'b1;
                        step_word.pc_jump = 1'b1;
                        last_step         = 1'b1;
                    end
                    OP_JC: begin
                        step_word.ir_out  = 1'b1;
                        step_word.pc_jump = carry_flag;
                        last_step         = 1'b1;
                    end
                    OP_JZ: begin
                        step_word.ir_out  = 1'b1;
                        step_word.pc_jump = zero_flag;
                        last_step         = 1'b1;
                    end
                    OP_OUT: begin
                        step_word.a_out    = 1'b1;
                        step_word.out_load = 1'b1;
                        last_step          = 1'b1;
                    end
                    OP_HLT:  go_halt = 1'b1;
                    default: last_step = 1'b1;
                endcase
            end
            S_T3: begin
                case (ir_opcode)
                    OP_LDA: begin
                        step_word.ram_out = 1'b1;
                        step_word.a_load  = 1'b1;
                        last_step         = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        step_word.ram_out = 1'b1;
                        step_word.b_load  = 1'b1;
                    end
                    OP_STA: begin
                        step_word.a_out     = 1'b1;
                        step_word.ram_write = 1'b1;
                        last_step           = 1'b1;
                    end
                    default: last_step = 1'b1;
                endcase
            end
            S_T4: begin
                last_step = 1'b1;
                if (ir_opcode == OP_ADD || ir_opcode == OP_SUB) begin
                    step_word.alu_out   = 1'b1;
                    step_word.a_load    = 1'b1;
                    step_word.flag_load = 1'b1;
                    step_word.alu_sub   = (ir_opcode == OP_SUB);
                end
            end
            default: step_word = '0;
        endcase

        // Programming mode freezes the step; nothing advances until it is released.
        if (!ram_prog_mode) begin
            unique case (state)
                S_IDLE:  state_next = S_T0;
                S_T0:    state_next = S_T1;
                S_T1:    state_next = (EARLY_END && last_step) ? S_T0 : S_T2;
                S_T2:    state_next = go_halt ? S_HALT
                                    : ((EARLY_END && last_step) ? S_T0 : S_T3);
                S_T3:    state_next = (EARLY_END && last_step) ? S_T0 : S_T4;
                S_T4:    state_next = S_T0;
                S_HALT:  state_next = S_HALT;
                default: state_next = S_IDLE;
            endcase
        end

        word = ram_prog_mode ? ctrl_word_t'('0) : step_word;
    end

    // At most one bus driver may be enabled in any step.
    always_comb begin
        assert ($onehot0({word.pc_out, word.ram_out, word.ir_out, word.a_out, word.alu_out}));
    end

    // State steps on the falling edge so the word is settled for the datapath rising edge.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            t_state <= TS_IDLE;
            halted  <= 1'b0;
        end else begin
            state   <= state_next;
            t_state <= tstate_of(state_next);
            halted  <= (state_next == S_HALT);
        end
    end

    // Flags capture the ALU result on the rising edge that ends an ADD/SUB T4.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            carry_flag <= 1'b0;
            zero_flag  <= 1'b0;
        end else if (word.flag_load) begin
            carry_flag <= alu_carry;
            zero_flag  <= alu_zero;
        end
    end

    // Port polarity: bus enables and loads on the shared bus are active-low.
    assign pc_bus_enable_n    = ~word.pc_out;
    assign pc_count           =  word.pc_count;
    assign pc_jump            =  word.pc_jump;
    assign ram_load_mar_reg   = ~word.mar_load;
    assign ram_output_enable  = ~word.ram_out;
    assign ram_control_signal =  word.ram_write;
    assign ir_load_n          = ~word.ir_load;
    assign ir_bus_enable_n    = ~word.ir_out;
    assign reg_a_load_n       = ~word.a_load;
    assign reg_a_bus_enable_n = ~word.a_out;
    assign reg_b_load_n       = ~word.b_load;
    assign alu_enable         =  word.alu_out;
    assign alu_subtract       =  word.alu_sub;
    assign out_load           =  word.out_load;

endmodule

// File: tb/tb_sap_u_control_sequencer.sv
// Directed bench for the SAP-U control sequencer with hand-computed control words.
`timescale 1ns/1ps

module tb_sap_u_control_sequencer;

    // Word bit order: pc_be_n pc_cnt pc_jmp mar_n ramoe_n ramwr irld_n irbe_n ald_n abe_n bld_n alu sub outld
    localparam logic [13:0] W_IDLE = 14'b10011011111000;
    localparam logic [13:0] W_T0   = 14'b00001011111000;
    localparam logic [13:0] W_T1   = 14'b11010001111000;
    localparam logic [13:0] W_ADR  = 14'b10001010111000;
    localparam logic [13:0] W_LDA3 = 14'b10010011011000;
    localparam logic [13:0] W_ADD3 = 14'b10010011110000;
    localparam logic [13:0] W_ADD4 = 14'b10011011011100;
    localparam logic [13:0] W_SUB4 = 14'b10011011011110;
    localparam logic [13:0] W_LDI  = 14'b10011010011000;
    localparam logic [13:0] W_JMP  = 14'b10111010111000;
    localparam logic [13:0] W_IRO  = 14'b10011010111000;
    localparam logic [13:0] W_OUT  = 14'b10011011101001;

    logic       clk;
    logic       reset;
    logic       ram_prog_mode;
    logic [3:0] ir_opcode;
    logic       alu_carry;
    logic       alu_zero;
    logic       pc_bus_enable_n;
    logic       pc_count;
    logic       pc_jump;
    logic       ram_load_mar_reg;
    logic       ram_output_enable;
    logic       ram_control_signal;
    logic       ir_load_n;
    logic       ir_bus_enable_n;
    logic       reg_a_load_n;
    logic       reg_a_bus_enable_n;
    logic       reg_b_load_n;
    logic       alu_enable;
    logic       alu_subtract;
    logic       out_load;
    logic       halted;
    logic [2:0] t_state;
    logic [13:0] word_obs;

    int n_cmp = 0;
    int n_bad = 0;

    sap_u_control_sequencer #(.EARLY_END(1'b1), .OPC_W(4)) dut (
        .clk                (clk),
        .reset              (reset),
        .ram_prog_mode      (ram_prog_mode),
        .ir_opcode          (ir_opcode),
        .alu_carry          (alu_carry),
        .alu_zero           (alu_zero),
        .pc_bus_enable_n    (pc_bus_enable_n),
        .pc_count           (pc_count),
        .pc_jump            (pc_jump),
        .ram_load_mar_reg   (ram_load_mar_reg),
        .ram_output_enable  (ram_output_enable),
        .ram_control_signal (ram_control_signal),
        .ir_load_n          (ir_load_n),
        .ir_bus_enable_n    (ir_bus_enable_n),
        .reg_a_load_n       (reg_a_load_n),
        .reg_a_bus_enable_n (reg_a_bus_enable_n),
        .reg_b_load_n       (reg_b_load_n),
        .alu_enable         (alu_enable),
        .alu_subtract       (alu_subtract),
        .out_load           (out_load),
        .halted             (halted),
        .t_state            (t_state)
    );

    assign word_obs = {pc_bus_enable_n, pc_count, pc_jump, ram_load_mar_reg, ram_output_enable,
                       ram_control_signal, ir_load_n, ir_bus_enable_n, reg_a_load_n,
                       reg_a_bus_enable_n, reg_b_load_n, alu_enable, alu_subtract, out_load};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic expect_word(input string tag, input logic [13:0] exp_w, input logic [2:0] exp_t);
        check_eq({tag, ".word"}, 32'(word_obs), 32'(exp_w));
        check_eq({tag, ".t"}, 32'(t_state), 32'(exp_t));
    endtask

    // Advance one step: outputs change on the falling edge, checked 1ns later.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    initial begin
        reset         = 1'b0;
        ram_prog_mode = 1'b0;
        ir_opcode     = 4'h0;
        alu_carry     = 1'b0;
        alu_zero      = 1'b0;

        // Reset and first fetch
        repeat (3) @(negedge clk);
        #1;
        expect_word("rst", W_IDLE, 3'd7);
        check_eq("rst.halted", 32'(halted), 32'd0);
        reset = 1'b1;
        #1;
        expect_word("rel", W_IDLE, 3'd7);
        step();  expect_word("fetch.t0", W_T0, 3'd0);

        // LDI: T2 IR out + A load, then straight back to T0
        ir_opcode = 4'h5;
        step();  expect_word("ldi.t1", W_T1, 3'd1);
        step();  expect_word("ldi.t2", W_LDI, 3'd2);
        step();  expect_word("ldi.end", W_T0, 3'd0);

        // ADD with carry=1 zero=0 latched at the end of T4
        ir_opcode = 4'h2;
        step();  expect_word("add.t1", W_T1, 3'd1);
        step();  expect_word("add.t2", W_ADR, 3'd2);
        step();  expect_word("add.t3", W_ADD3, 3'd3);
        alu_carry = 1'b1;
        alu_zero  = 1'b0;
        step();  expect_word("add.t4", W_ADD4, 3'd4);
        step();  expect_word("add.end", W_T0, 3'd0);
        alu_carry = 1'b0;
        alu_zero  = 1'b1;

        // JC taken, JZ not taken
        ir_opcode = 4'h7;
        step();  step();  expect_word("jc.taken", W_JMP, 3'd2);
        step();  expect_word("jc.end", W_T0, 3'd0);
        ir_opcode = 4'h8;
        step();  step();  expect_word("jz.not", W_IRO, 3'd2);
        step();

        // SUB with zero=1: subtract only in T4
        ir_opcode = 4'h3;
        step();  step();
        step();  expect_word("sub.t3", W_ADD3, 3'd3);
        step();  expect_word("sub.t4", W_SUB4, 3'd4);
        step();  expect_word("sub.end", W_T0, 3'd0);
        alu_carry = 1'b1;
        alu_zero  = 1'b0;
        ir_opcode = 4'h8;
        step();  step();  expect_word("jz.taken", W_JMP, 3'd2);
        step();
        ir_opcode = 4'h7;
        step();  step();  expect_word("jc.not", W_IRO, 3'd2);
        step();

        // LDA frozen in T3 by programming mode
        ir_opcode = 4'h1;
        step();  step();  expect_word("lda.t2", W_ADR, 3'd2);
        step();  expect_word("lda.t3", W_LDA3, 3'd3);
        ram_prog_mode = 1'b1;
        #1;
        expect_word("prog.on", W_IDLE, 3'd3);
        for (int i = 0; i < 4; i++) begin
            step();  expect_word("prog.hold", W_IDLE, 3'd3);
        end
        ram_prog_mode = 1'b0;
        #1;
        expect_word("prog.off", W_LDA3, 3'd3);
        step();  expect_word("lda.end", W_T0, 3'd0);

        // Reset in the middle of ADD T3 clears state and flags (zero_flag was 1)
        ir_opcode = 4'h2;
        alu_carry = 1'b1;
        alu_zero  = 1'b1;
        step();  step();
        step();  expect_word("add2.t3", W_ADD3, 3'd3);
        reset = 1'b0;
        #1;
        expect_word("midrst", W_IDLE, 3'd7);
        step();  expect_word("midrst.hold", W_IDLE, 3'd7);
        reset = 1'b1;
        step();  expect_word("midrst.t0", W_T0, 3'd0);
        ir_opcode = 4'h8;
        step();  step();  expect_word("jz.cleared", W_IRO, 3'd2);
        step();

        // NOP ends after T1; OUT drives A into the output register
        ir_opcode = 4'h0;
        step();  expect_word("nop.t1", W_T1, 3'd1);
        step();  expect_word("nop.end", W_T0, 3'd0);
        ir_opcode = 4'hA;
        step();  step();  expect_word("op_a.end", W_T0, 3'd0);
        ir_opcode = 4'hE;
        step();  step();  expect_word("out.t2", W_OUT, 3'd2);
        step();

        // HLT: no strobes in T2, then halted with an inactive word
        ir_opcode = 4'hF;
        step();  step();  expect_word("hlt.t2", W_IDLE, 3'd2);
        check_eq("hlt.t2.halted", 32'(halted), 32'd0);
        for (int i = 0; i < 20; i++) begin
            step();
            check_eq("halt.word", 32'(word_obs), 32'(W_IDLE));
            check_eq("halt.flag", 32'(halted), 32'd1);
        end
        check_eq("halt.t", 32'(t_state), 32'd7);
        reset = 1'b0;
        #1;
        check_eq("halt.rst", 32'(halted), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
